// File: rtl/rom_bus_bridge_pkg.sv
// rom_bus_bridge_pkg: shared FSM encodings and default address/fill constants
// for the monitor-ROM bus bridge and its optional prefetch buffer.
package rom_bus_bridge_pkg;

    localparam logic [15:0] DEF_WIN_BASE  = 16'hF800;
    localparam logic [15:0] DEF_CTRL_ADDR = 16'hC0F0;
    localparam logic [7:0]  DEF_FILL      = 8'hFF;

    // PF_ISSUE/PF_CAP are only reachable with ROM_PREFETCH_EN.
    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPTURE,
        S_RESP,
        S_PF_ISSUE,
        S_PF_CAP
    } state_t;

endpackage

// File: rtl/rom_bus_bridge_prefetch.sv
// rom_bus_bridge_prefetch: one-entry ROM prefetch buffer (data, {bank,offset}
// tag, valid). Only built with ROM_PREFETCH_EN.
// Ports: clock/reset; i_inv clears valid; i_load captures i_load_tag and
// i_load_data; o_hit = valid and tag matches i_look_tag; o_data = buffered byte.
`ifdef ROM_PREFETCH_EN
module rom_bus_bridge_prefetch #(
    parameter int DW = 8,
    parameter int TW = 14
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          i_inv,
    input  logic          i_load,
    input  logic [TW-1:0] i_load_tag,
    input  logic [DW-1:0] i_load_data,
    input  logic [TW-1:0] i_look_tag,
    output logic          o_hit,
    output logic [DW-1:0] o_data
);

    logic          r_valid;
    logic [TW-1:0] r_tag;
    logic [DW-1:0] r_data;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_tag   <= '0;
            r_data  <= '0;
        end else if (i_inv) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_tag   <= i_load_tag;
            r_data  <= i_load_data;
        end
    end

    assign o_hit  = r_valid && (r_tag == i_look_tag);
    assign o_data = r_data;

endmodule
`endif

// File: rtl/rom_bus_bridge.sv
// rom_bus_bridge: 6502 bus front end mapping the CPU ROM window onto a banked
// synchronous ROM, with a CPU-writable bank-select register.
// Ports: clock/reset (sync, high); cpu_addr/req/we/wdata in, cpu_rdata/ack
// out; rom_a/rom_ce to ROM, rom_data from ROM; bank = current bank.
// Optional macro ROM_PREFETCH_EN adds a one-entry next-offset prefetch.
module rom_bus_bridge
    import rom_bus_bridge_pkg::*;
#(
    parameter int          DW        = 8,
    parameter int          AW        = 14,
    parameter int          WIN_AW    = 11,
    parameter logic [15:0] WIN_BASE  = DEF_WIN_BASE,
    parameter logic [15:0] CTRL_ADDR = DEF_CTRL_ADDR,
    parameter logic [DW-1:0] FILL    = DEF_FILL,
    localparam int         BANK_W    = AW - WIN_AW
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [15:0]       cpu_addr,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [DW-1:0]     cpu_wdata,
    output logic [DW-1:0]     cpu_rdata,
    output logic              cpu_ack,
    output logic [AW-1:0]     rom_a,
    output logic              rom_ce,
    input  logic [DW-1:0]     rom_data,
    output logic [BANK_W-1:0] bank
);

    state_t              r_state;
    logic [DW-1:0]       r_cpu_rdata;
    logic                r_cpu_ack;
    logic [AW-1:0]       r_rom_a;
    logic                r_rom_ce;
    logic [BANK_W-1:0]   r_bank;

    logic                w_win;
    logic [WIN_AW-1:0]   w_off;
    logic                w_rd_win;
    logic                w_ctrl_wr;
    logic                w_unused;

    assign w_win     = cpu_addr[15:WIN_AW] == WIN_BASE[15:WIN_AW];
    assign w_off     = cpu_addr[WIN_AW-1:0];
    assign w_rd_win  = cpu_req && !cpu_we && w_win;
    assign w_ctrl_wr = cpu_req && cpu_we && (cpu_addr == CTRL_ADDR);
    assign w_unused  = ^cpu_wdata[DW-1:BANK_W];

`ifdef ROM_PREFETCH_EN
    logic              w_hit;
    logic [DW-1:0]     w_buf_data;
    logic              w_pf_load;
    logic              w_inv;
    logic [WIN_AW-1:0] r_pf_off;
    logic              r_pf_req;

    assign w_pf_load = (r_state == S_PF_CAP);
    assign w_inv     = (r_state == S_IDLE) && w_ctrl_wr;

    rom_bus_bridge_prefetch #(
        .DW (DW),
        .TW (AW)
    ) u_pf (
        .clock       (clock),
        .reset       (reset),
        .i_inv       (w_inv),
        .i_load      (w_pf_load),
        .i_load_tag  (r_rom_a),
        .i_load_data (rom_data),
        .i_look_tag  ({r_bank, w_off}),
        .o_hit       (w_hit),
        .o_data      (w_buf_data)
    );
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cpu_rdata <= '0;
            r_cpu_ack   <= 1'b0;
            r_rom_a     <= '0;
            r_rom_ce    <= 1'b0;
            r_bank      <= '0;
`ifdef ROM_PREFETCH_EN
            r_pf_off    <= '0;
            r_pf_req    <= 1'b0;
`endif
        end else begin
            // ack and ce are single-cycle pulses
            r_cpu_ack <= 1'b0;
            r_rom_ce  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_rd_win) begin
`ifdef ROM_PREFETCH_EN
                        r_pf_off <= w_off;
                        // last offset of the window never prefetches
                        r_pf_req <= (w_off != '1);
                        if (w_hit) begin
                            r_cpu_rdata <= w_buf_data;
                            r_cpu_ack   <= 1'b1;
                            r_state     <= S_RESP;
                        end else begin
                            r_rom_ce <= 1'b1;
                            r_rom_a  <= {r_bank, w_off};
                            r_state  <= S_ISSUE;
                        end
`else
                        r_rom_ce <= 1'b1;
                        r_rom_a  <= {r_bank, w_off};
                        r_state  <= S_ISSUE;
`endif
                    end else if (cpu_req) begin
`ifdef ROM_PREFETCH_EN
                        r_pf_req <= 1'b0;
`endif
                        if (!cpu_we)
                            r_cpu_rdata <= FILL;
                        if (w_ctrl_wr)
                            r_bank <= cpu_wdata[BANK_W-1:0];
                        r_cpu_ack <= 1'b1;
                        r_state   <= S_RESP;
                    end
                end
                S_ISSUE: begin
                    r_state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    r_cpu_rdata <= rom_data;
                    r_cpu_ack   <= 1'b1;
                    r_state     <= S_RESP;
                end
                S_RESP: begin
`ifdef ROM_PREFETCH_EN
                    r_pf_req <= 1'b0;
                    if (r_pf_req) begin
                        r_rom_ce <= 1'b1;
                        r_rom_a  <= {r_bank, r_pf_off + WIN_AW'(1)};
                        r_state  <= S_PF_ISSUE;
                    end else begin
                        r_state <= S_IDLE;
                    end
`else
                    r_state <= S_IDLE;
`endif
                end
                S_PF_ISSUE: begin
                    r_state <= S_PF_CAP;
                end
                S_PF_CAP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cpu_rdata = r_cpu_rdata;
    assign cpu_ack   = r_cpu_ack;
    assign rom_a     = r_rom_a;
    assign rom_ce    = r_rom_ce;
    assign bank      = r_bank;

endmodule

// File: tb/tb_rom_bus_bridge.sv
// tb_rom_bus_bridge: directed self-checking bench for rom_bus_bridge with a
// behavioural synchronous ROM; prefetch expectations follow ROM_PREFETCH_EN.
module tb_rom_bus_bridge;

`ifdef ROM_PREFETCH_EN
    localparam bit PF = 1'b1;
`else
    localparam bit PF = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] cpu_addr = '0;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [7:0]  cpu_wdata = '0;
    logic [7:0]  cpu_rdata;
    logic        cpu_ack;
    logic [13:0] rom_a;
    logic        rom_ce;
    logic [7:0]  rom_data = '0;
    logic [2:0]  bank;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    rom_bus_bridge dut (
        .clock     (clock),
        .reset     (reset),
        .cpu_addr  (cpu_addr),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ack   (cpu_ack),
        .rom_a     (rom_a),
        .rom_ce    (rom_ce),
        .rom_data  (rom_data),
        .bank      (bank)
    );

    // ROM image: byte 0 = A9, else a[7:0] ^ a[13:8] ^ 5A
    function automatic logic [7:0] img(input logic [13:0] a);
        if (a == 14'd0)
            return 8'hA9;
        return a[7:0] ^ {2'b00, a[13:8]} ^ 8'h5A;
    endfunction

    always @(posedge clock)
        if (rom_ce)
            rom_data <= img(rom_a);

    // Drives one transaction and records what the DUT did, cycle by cycle.
    // lat = cycles from request cycle to ack (-1 if none within budget).
    task automatic txn(
        input  logic [15:0] a,
        input  logic        we,
        input  logic [7:0]  wd,
        input  int          gap,
        output int          lat,
        output logic [7:0]  rd,
        output int          ce_n,
        output int          ce_k,
        output logic [13:0] ce_a,
        output logic        ack_after,
        output logic        ce_after
    );
        repeat (gap) @(posedge clock);
        @(posedge clock);
        #1;
        cpu_req = 1'b1;
        cpu_addr = a;
        cpu_we = we;
        cpu_wdata = wd;
        lat = -1;
        rd = '0;
        ce_n = 0;
        ce_k = -1;
        ce_a = '0;
        for (int k = 1; k <= 12 && lat < 0; k++) begin
            @(posedge clock);
            @(negedge clock);
            if (rom_ce) begin
                ce_n++;
                ce_a = rom_a;
                if (ce_k < 0)
                    ce_k = k;
            end
            if (cpu_ack) begin
                lat = k;
                rd = cpu_rdata;
                cpu_req = 1'b0;
            end
        end
        cpu_req = 1'b0;
        @(posedge clock);
        @(negedge clock);
        ack_after = cpu_ack;
        ce_after = rom_ce;
    endtask

    int lat, ce_n, ce_k;
    logic [7:0] rd;
    logic [13:0] ce_a;
    logic ack_after, ce_after;

    task automatic test_reset;
        repeat (2) @(posedge clock);
        @(negedge clock);
        n_chk++; if (cpu_rdata !== 8'h00) begin n_fail++;
            $display("FAIL rst_rdata got %h want 00", cpu_rdata); end
        n_chk++; if (cpu_ack !== 1'b0) begin n_fail++;
            $display("FAIL rst_ack got %b want 0", cpu_ack); end
        n_chk++; if (rom_a !== 14'h0) begin n_fail++;
            $display("FAIL rst_rom_a got %h want 0", rom_a); end
        n_chk++; if (rom_ce !== 1'b0) begin n_fail++;
            $display("FAIL rst_rom_ce got %b want 0", rom_ce); end
        n_chk++; if (bank !== 3'd0) begin n_fail++;
            $display("FAIL rst_bank got %0d want 0", bank); end
        reset = 1'b0;
    endtask

    task automatic test_window_read;
        txn(16'hF800, 1'b0, 8'h00, 2, lat, rd, ce_n, ce_k, ce_a,
            ack_after, ce_after);
        n_chk++; if (lat !== 3) begin n_fail++;
            $display("FAIL f800_lat got %0d want 3", lat); end
        n_chk++; if (ce_k !== 1) begin n_fail++;
            $display("FAIL f800_ce_cycle got %0d want 1", ce_k); end
        n_chk++; if (ce_n !== 1) begin n_fail++;
            $display("FAIL f800_ce_count got %0d want 1", ce_n); end
        n_chk++; if (ce_a !== 14'h0000) begin n_fail++;
            $display("FAIL f800_rom_a got %h want 0000", ce_a); end
        n_chk++; if (rd !== 8'hA9) begin n_fail++;
            $display("FAIL f800_rdata got %h want A9", rd); end
        n_chk++; if (ack_after !== 1'b0) begin n_fail++;
            $display("FAIL f800_ack_twice got %b want 0", ack_after); end
    endtask

    task automatic test_bank_read;
        txn(16'hC0F0, 1'b1, 8'h05, 2, lat, rd, ce_n, ce_k, ce_a,
            ack_after, ce_after);
        n_chk++; if (lat !== 1) begin n_fail++;
            $display("FAIL bankwr_lat got %0d want 1", lat); end
        n_chk++; if (bank !== 3'd5) begin n_fail++;
            $display("FAIL bankwr_bank got %0d want 5", bank); end
        txn(16'hFFFC, 1'b0, 8'h00, 2, lat, rd, ce_n, ce_k, ce_a,
            ack_after, ce_after);
        n_chk++; if (lat !== 3) begin n_fail++;
            $display("FAIL fffc_lat got %0d want 3", lat); end
        n_chk++; if (ce_a !== 14'h2FFC) begin n_fail++;
            $display("FAIL fffc_rom_a got %h want 2FFC", ce_a); end
        n_chk++; if (rd !== 8'h89) begin n_fail++;
            $display("FAIL fffc_rdata got %h want 89", rd); end
    endtask

    task automatic test_outside;
        txn(16'hC000, 1'b0, 8'h00, 2, lat, rd, ce_n, ce_k, ce_a,
            ack_after, ce_after);
        n_chk++; if (lat !== 1) begin n_fail++;
            $display("FAIL c000_lat got %0d want 1", lat); end
        n_chk++; if (rd !== 8'hFF) begin n_fail++;
            $display("FAIL c000_rdata got %h want FF", rd); end
        n_chk++; if (ce_n !== 0) begin n_fail++;
            $display("FAIL c000_ce got %0d want 0", ce_n); end
        txn(16'hF800, 1'b1, 8'h07, 2, lat, rd, ce_n, ce_k, ce_a,
            ack_after, ce_after);
        n_chk++; if (lat !== 1) begin n_fail++;
            $display("FAIL winwr_lat got %0d want 1", lat); end
        n_chk++; if (bank !== 3'd5) begin n_fail++;
            $display("FAIL winwr_bank got %0d want 5", bank); end
        n_chk++; if (ce_n !== 0) begin n_fail++;
            $display("FAIL winwr_ce got %0d want 0", ce_n); end
    endtask

    // req held one cycle past ack: second request, no double ack
    task automatic test_protocol_error;
        repeat (3) @(posedge clock);
        #1;
        cpu_req = 1'b1;
        cpu_addr = 16'hC000;
        cpu_we = 1'b0;
        @(posedge clock);
        @(negedge clock);
        n_chk++; if (cpu_ack !== 1'b1) begin n_fail++;
            $display("FAIL perr_ack1 got %b want 1", cpu_ack); end
        @(negedge clock);
        n_chk++; if (cpu_ack !== 1'b0) begin n_fail++;
            $display("FAIL perr_gap got %b want 0", cpu_ack); end
        @(posedge clock);
        #1;
        cpu_req = 1'b0;
        @(negedge clock);
        n_chk++; if (cpu_ack !== 1'b1) begin n_fail++;
            $display("FAIL perr_ack2 got %b want 1", cpu_ack); end
        @(negedge clock);
        n_chk++; if (cpu_ack !== 1'b0) begin n_fail++;
            $display("FAIL perr_end got %b want 0", cpu_ack); end
    endtask

    task automatic test_mid_reset;
        repeat (3) @(posedge clock);
        #1;
        cpu_req = 1'b1;
        cpu_addr = 16'hF900;
        cpu_we = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        cpu_req = 1'b0;
        @(negedge clock);
        n_chk++; if (cpu_ack !== 1'b0) begin n_fail++;
            $display("FAIL mrst_ack got %b want 0", cpu_ack); end
        n_chk++; if (rom_ce !== 1'b0) begin n_fail++;
            $display("FAIL mrst_ce got %b want 0", rom_ce); end
        n_chk++; if (cpu_rdata !== 8'h00) begin n_fail++;
            $display("FAIL mrst_rdata got %h want 00", cpu_rdata); end
        n_chk++; if (rom_a !== 14'h0) begin n_fail++;
            $display("FAIL mrst_rom_a got %h want 0", rom_a); end
        n_chk++; if (bank !== 3'd0) begin n_fail++;
            $display("FAIL mrst_bank got %0d want 0", bank); end
        @(negedge clock);
        n_chk++; if (cpu_ack !== 1'b0) begin n_fail++;
            $display("FAIL mrst_late_ack got %b want 0", cpu_ack); end
    endtask

    task automatic test_back_to_back;
        txn(16'hF801, 1'b0, 8'h00, 2, lat, rd, ce_n, ce_k, ce_a,
            ack_after, ce_after);
        n_chk++; if (lat !== 3) begin n_fail++;
            $display("FAIL f801_lat got %0d want 3", lat); end
        n_chk++; if (rd !== 8'h5B) begin n_fail++;
            $display("FAIL f801_rdata got %h want 5B", rd); end
        txn(16'hF802, 1'b0, 8'h00, 0, lat, rd, ce_n, ce_k, ce_a,
            ack_after, ce_after);
        n_chk++; if (lat !== (PF ? 2 : 3)) begin n_fail++;
            $display("FAIL f802_lat got %0d want %0d", lat, PF ? 2 : 3); end
        n_chk++; if (rd !== 8'h58) begin n_fail++;
            $display("FAIL f802_rdata got %h want 58", rd); end
        n_chk++; if (ce_n !== (PF ? 0 : 1)) begin n_fail++;
            $display("FAIL f802_ce got %0d want %0d", ce_n, PF ? 0 : 1); end
    endtask

    task automatic test_prefetch;
        txn(16'hFA00, 1'b0, 8'h00, 2, lat, rd, ce_n, ce_k, ce_a,
            ack_after, ce_after);
        n_chk++; if (rd !== 8'h58) begin n_fail++;
            $display("FAIL fa00_rdata got %h want 58", rd); end
        n_chk++; if (ce_after !== PF) begin n_fail++;
            $display("FAIL fa00_pf_ce got %b want %b", ce_after, PF); end
        txn(16'hFA01, 1'b0, 8'h00, 2, lat, rd, ce_n, ce_k, ce_a,
            ack_after, ce_after);
        n_chk++; if (lat !== (PF ? 1 : 3)) begin n_fail++;
            $display("FAIL fa01_lat got %0d want %0d", lat, PF ? 1 : 3); end
        n_chk++; if (rd !== 8'h59) begin n_fail++;
            $display("FAIL fa01_rdata got %h want 59", rd); end
        n_chk++; if (ce_n !== (PF ? 0 : 1)) begin n_fail++;
            $display("FAIL fa01_ce got %0d want %0d", ce_n, PF ? 0 : 1); end
        txn(16'hC0F0, 1'b1, 8'h00, 2, lat, rd, ce_n, ce_k, ce_a,
            ack_after, ce_after);
        txn(16'hFA02, 1'b0, 8'h00, 2, lat, rd, ce_n, ce_k, ce_a,
            ack_after, ce_after);
        n_chk++; if (lat !== 3) begin n_fail++;
            $display("FAIL fa02_inv_lat got %0d want 3", lat); end
        n_chk++; if (rd !== 8'h5A) begin n_fail++;
            $display("FAIL fa02_rdata got %h want 5A", rd); end
    endtask

    task automatic test_no_wrap;
        txn(16'hFFFF, 1'b0, 8'h00, 2, lat, rd, ce_n, ce_k, ce_a,
            ack_after, ce_after);
        n_chk++; if (rd !== 8'hA2) begin n_fail++;
            $display("FAIL ffff_rdata got %h want A2", rd); end
        n_chk++; if (ce_a !== 14'h07FF) begin n_fail++;
            $display("FAIL ffff_rom_a got %h want 07FF", ce_a); end
        n_chk++; if (ce_after !== 1'b0) begin n_fail++;
            $display("FAIL ffff_pf_ce got %b want 0", ce_after); end
        txn(16'hF800, 1'b0, 8'h00, 2, lat, rd, ce_n, ce_k, ce_a,
            ack_after, ce_after);
        n_chk++; if (lat !== 3) begin n_fail++;
            $display("FAIL wrap_f800_lat got %0d want 3", lat); end
        n_chk++; if (rd !== 8'hA9) begin n_fail++;
            $display("FAIL wrap_f800_rdata got %h want A9", rd); end
    endtask

    initial begin
        test_reset();
        test_window_read();
        test_bank_read();
        test_outside();
        test_protocol_error();
        test_mid_reset();
        test_back_to_back();
        test_prefetch();
        test_no_wrap();
        repeat (2) @(posedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
